// File: rtl/apb_bridge_pkg.sv
// Shared types and width helpers for the APB side of the AHB-to-APB bridge.
// The command/response structs describe the FIFO word layouts at the default
// 32-bit address/data widths. Modules with other widths derive field
// positions from cmd_w()/rsp_w().
package apb_bridge_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Command word: {write, strb, addr, wdata}
    function automatic int cmd_w(input int aw, input int dw);
        return 1 + dw / 8 + aw + dw;
    endfunction

    // Response word: {timeout, slverr, rdata}
    function automatic int rsp_w(input int dw);
        return dw + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_t;

    typedef struct packed {
        logic                    write;
        logic [DEF_DATA_W/8-1:0] strb;
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_DATA_W-1:0]   wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic                  timeout;
        logic                  slverr;
        logic [DEF_DATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// PREADY timeout counter for the ACCESS phase.
// Ports:
//   rclk, reset : clock, synchronous active-high reset
//   clr         : clear the count (asserted in the cycle before ACCESS)
//   en          : high while in ACCESS
//   pready      : slave ready; a ready cycle never counts and never expires
//   expired     : combinational abort strobe, high in the last permitted
//                 ACCESS cycle when the slave is still not ready
// TIMEOUT = 0 disables the abort entirely.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic rclk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic pready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{rclk, reset, clr, en, pready};
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge rclk) begin
                if (reset || clr)
                    cnt <= '0;
                else if (en && !pready)
                    cnt <= cnt + 1'b1;
            end

            // The count equals the number of wait cycles already spent, so
            // the TIMEOUT-th unready cycle is the one where cnt hits LAST.
            assign expired = en && !pready && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB command master: pops commands from the clock-crossing command FIFO,
// runs one APB transfer each, pushes one response per command.
// Ports:
//   rclk, reset          : APB clock, synchronous active-high reset
//   cmd_empty/ren/rdata  : command FIFO read side (rdata valid cycle after ren)
//   rsp_full/wen/wdata   : response FIFO write side
//   psel..pstrb          : APB master outputs (registered)
//   pready/pslverr/prdata: APB slave response
//   busy                 : FSM not in IDLE
//   err_count            : saturating count of slverr/timeout responses pushed
module apb_cmd_master
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                          rclk,
    input  logic                          reset,
    input  logic                          cmd_empty,
    output logic                          cmd_ren,
    input  logic [cmd_w(ADDR_W,DATA_W)-1:0] cmd_rdata,
    input  logic                          rsp_full,
    output logic                          rsp_wen,
    output logic [rsp_w(DATA_W)-1:0]      rsp_wdata,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_W-1:0]             paddr,
    output logic [DATA_W-1:0]             pwdata,
    output logic [DATA_W/8-1:0]           pstrb,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_W-1:0]             prdata,
    output logic                          busy,
    output logic [15:0]                   err_count
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = cmd_w(ADDR_W, DATA_W);
    localparam int RSP_W  = rsp_w(DATA_W);

    apb_state_t state;

    logic              c_write;
    logic [STRB_W-1:0] c_strb;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;

    assign c_write = cmd_rdata[CMD_W-1];
    assign c_strb  = cmd_rdata[DATA_W+ADDR_W +: STRB_W];
    assign c_addr  = cmd_rdata[DATA_W +: ADDR_W];
    assign c_wdata = cmd_rdata[DATA_W-1:0];

    logic to_clr, to_en, to_expired;
    assign to_clr = (state == ST_SETUP);
    assign to_en  = (state == ST_ACCESS);

    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .rclk    (rclk),
        .reset   (reset),
        .clr     (to_clr),
        .en      (to_en),
        .pready  (pready),
        .expired (to_expired)
    );

    // FIFO strobes are decoded so RESP can push and pop in the same cycle.
    // Gated by reset so nothing moves in either FIFO while reset is held.
    logic rsp_go, rsp_err;
    assign rsp_go  = !reset && (state == ST_RESP) && !rsp_full;
    assign rsp_wen = rsp_go;
    assign cmd_ren = !reset && !cmd_empty && ((state == ST_IDLE) || rsp_go);
    assign rsp_err = rsp_wdata[RSP_W-1] | rsp_wdata[RSP_W-2];

    always_ff @(posedge rclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_wdata <= '0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cmd_empty) begin
                        state <= ST_FETCH;
                        busy  <= 1'b1;
                    end
                end
                // The APB output registers double as the command register;
                // they hold from SETUP through the last ACCESS cycle.
                ST_FETCH: begin
                    psel   <= 1'b1;
                    pwrite <= c_write;
                    paddr  <= c_addr;
                    pwdata <= c_write ? c_wdata : '0;
                    pstrb  <= c_write ? c_strb  : '0;
                    state  <= ST_SETUP;
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready in the expiry cycle wins: checked first.
                    if (pready) begin
                        rsp_wdata <= {1'b0, pslverr, (pwrite ? {DATA_W{1'b0}} : prdata)};
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (to_expired) begin
                        rsp_wdata <= {1'b1, 1'b0, {DATA_W{1'b0}}};
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!rsp_full) begin
                        if (rsp_err && (err_count != 16'hFFFF))
                            err_count <= err_count + 16'd1;
                        if (!cmd_empty) begin
                            state <= ST_FETCH;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized + directed bench for apb_cmd_master. Models the command FIFO
// (registered read), the response FIFO and an APB slave with per-command
// wait-state plans; expected responses come from the transfer rules.
module tb_apb_cmd_master;
    import apb_bridge_pkg::*;

    localparam int TO = 8;

    logic        rclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_empty = 1'b1;
    logic        cmd_ren;
    logic [68:0] cmd_rdata = '0;
    logic        rsp_full = 1'b0;
    logic        rsp_wen;
    logic [33:0] rsp_wdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [31:0] prdata = '0;
    logic        busy;
    logic [15:0] err_count;

    always #5 rclk = ~rclk;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .rclk(rclk), .reset(reset), .cmd_empty(cmd_empty), .cmd_ren(cmd_ren),
        .cmd_rdata(cmd_rdata), .rsp_full(rsp_full), .rsp_wen(rsp_wen),
        .rsp_wdata(rsp_wdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .pslverr(pslverr), .prdata(prdata), .busy(busy), .err_count(err_count)
    );

    typedef struct {
        apb_cmd_t    cmd;
        int          waits;   // unready ACCESS cycles before pready
        logic        slverr;
        logic [31:0] rdata;
    } plan_t;

    apb_cmd_t    cmd_q[$];
    plan_t       plan_q[$];
    logic [33:0] exp_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, pops = 0, rsps = 0, viol = 0, err_model = 0;
    int ren_cyc = 0, wen_cyc = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model_rsp(input plan_t p);
        if (p.waits >= TO) return {2'b10, 32'h0};
        return {1'b0, p.slverr, (p.cmd.write ? 32'h0 : p.rdata)};
    endfunction

    function automatic logic [68:0] model_apb(input apb_cmd_t c);
        return {c.write, (c.write ? c.strb : 4'h0), c.addr, (c.write ? c.wdata : 32'h0)};
    endfunction

    function automatic int model_len(input plan_t p);
        return (p.waits < TO) ? p.waits + 1 : TO;
    endfunction

    // Command / response FIFO models
    initial forever begin
        @(posedge rclk);
        cyc++;
        if (cmd_ren) begin
            pops++;
            ren_cyc = cyc;
            if (cmd_empty || cmd_q.size() == 0) viol++;
            else cmd_rdata <= cmd_q.pop_front();
        end
        if (rsp_wen) begin
            logic [33:0] e;
            wen_cyc = cyc;
            rsps++;
            if (rsp_full) viol++;
            if (exp_q.size() == 0) chk("rsp_extra", 128'(rsp_wdata), 128'(0));
            else begin
                e = exp_q.pop_front();
                chk("rsp", 128'(rsp_wdata), 128'(e));
                if ((e[33] || e[32]) && err_model < 65535) err_model++;
            end
        end
        cmd_empty <= (cmd_q.size() == 0);
    end

    // APB slave model, evaluated mid-cycle on the registered APB outputs
    plan_t cur;
    int    acc = 0;
    bit    in_xfer = 0;
    initial forever begin
        @(negedge rclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
        if (reset) begin
            if (in_xfer) begin
                logic [33:0] drop;
                drop = exp_q.pop_back();   // in-flight command gets no response
                in_xfer = 0;
            end
        end else if (psel && !penable) begin
            if (plan_q.size() == 0) chk("plan_underflow", 128'(1), 128'(0));
            else begin
                cur = plan_q.pop_front();
                exp_q.push_back(model_rsp(cur));
                chk("setup", 128'({pwrite, pstrb, paddr, pwdata}), 128'(model_apb(cur.cmd)));
                acc = 0;
                in_xfer = 1;
            end
        end else if (psel && penable) begin
            chk("hold", 128'({pwrite, pstrb, paddr, pwdata}), 128'(model_apb(cur.cmd)));
            pready  = (acc == cur.waits);
            pslverr = pready ? cur.slverr : 1'($urandom_range(0, 1));
            prdata  = pready ? cur.rdata : $urandom;
            acc++;
        end else if (in_xfer) begin
            chk("pen_len", 128'(acc), 128'(model_len(cur)));
            in_xfer = 0;
        end
    end

    task automatic push(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic slverr,
                        input logic [31:0] rdata);
        plan_t p;
        p.cmd.write = wr;
        p.cmd.strb  = strb;
        p.cmd.addr  = addr;
        p.cmd.wdata = wdata;
        p.waits     = waits;
        p.slverr    = slverr;
        p.rdata     = rdata;
        cmd_q.push_back(p.cmd);
        plan_q.push_back(p);
    endtask

    task automatic push_rand();
        push(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
             $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 300 && rsps < n; i++) @(posedge rclk);
        #1;
        if (rsps < n) chk("wait_rsp", 128'(rsps), 128'(n));
    endtask

    initial begin
        int base, p0, r0, target;

        // reset state
        repeat (3) @(posedge rclk);
        #1;
        chk("reset_vals", 128'({psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ren,
                                rsp_wen, rsp_wdata, busy, err_count}), 128'(0));
        reset = 1'b0;
        repeat (2) @(posedge rclk);
        #1;

        // zero-wait write
        push(1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 0, 1'b0, 32'hA5A5A5A5);
        wait_rsp(1);
        chk("wr_lat", 128'(wen_cyc - ren_cyc), 128'(4));
        chk("wr_idle", 128'({busy, psel}), 128'(0));

        // read, 3 wait states
        push(1'b0, 4'h0, 32'h2004, 32'h0, 3, 1'b0, 32'h12345678);
        wait_rsp(2);
        chk("rd_lat", 128'(wen_cyc - ren_cyc), 128'(7));

        // read with slave error
        push(1'b0, 4'h0, 32'h3000, 32'h0, 1, 1'b1, 32'hCAFEF00D);
        wait_rsp(3);
        chk("err_cnt1", 128'(err_count), 128'(1));

        // hung slave -> timeout after TO access cycles
        push(1'b0, 4'h0, 32'h4000, 32'h0, 100, 1'b0, 32'h11111111);
        wait_rsp(4);
        chk("to_lat", 128'(wen_cyc - ren_cyc), 128'(3 + TO));
        chk("err_cnt2", 128'(err_count), 128'(2));

        // boundary: ready in the last permitted cycle vs one past it
        push(1'b0, 4'h0, 32'h5000, 32'h0, TO - 1, 1'b0, 32'h0BADF00D);
        push(1'b1, 4'h3, 32'h5004, 32'h77777777, TO, 1'b1, 32'h0);
        wait_rsp(6);
        chk("err_cnt3", 128'(err_count), 128'(err_model));

        // back-to-back with response backpressure on the 2nd response
        base = rsps;
        for (int i = 0; i < 4; i++)
            push(1'(i), 4'(i + 1), 32'h6000 + 32'(i * 4), $urandom, 0, 1'b0, $urandom);
        wait_rsp(base + 1);
        rsp_full = 1'b1;
        p0 = pops;
        repeat (10) @(posedge rclk);
        #1;
        chk("stall_pops", 128'(pops), 128'(p0));
        chk("stall_rsps", 128'(rsps), 128'(base + 1));
        chk("stall_state", 128'({busy, psel, penable}), 128'(3'b100));
        rsp_full = 1'b0;
        wait_rsp(base + 4);

        // reset during ACCESS
        push(1'b0, 4'h0, 32'h7000, 32'h0, 100, 1'b0, 32'h0);
        for (int i = 0; i < 50 && !(psel && penable); i++) @(posedge rclk);
        #1;
        chk("rst_reach_access", 128'(psel && penable), 128'(1));
        @(posedge rclk);
        #1;
        reset = 1'b1;
        @(posedge rclk);
        #1;
        chk("rst_apb", 128'({psel, penable, busy, rsp_wen, cmd_ren, err_count}), 128'(0));
        err_model = 0;
        reset = 1'b0;
        r0 = rsps;
        repeat (12) @(posedge rclk);
        #1;
        chk("rst_norsp", 128'(rsps), 128'(r0));
        push(1'b1, 4'h1, 32'h8000, 32'h00000042, 0, 1'b0, 32'h0);
        wait_rsp(r0 + 1);
        chk("post_rst_lat", 128'(wen_cyc - ren_cyc), 128'(4));

        // randomized traffic with random response backpressure
        target = rsps + 40;
        for (int i = 0; i < 40; i++) begin
            push_rand();
            repeat ($urandom_range(0, 3)) begin
                @(posedge rclk);
                #1;
                rsp_full = ($urandom_range(0, 3) == 0);
            end
        end
        for (int k = 0; k < 3000 && rsps < target; k++) begin
            @(posedge rclk);
            #1;
            rsp_full = ($urandom_range(0, 3) == 0);
        end
        rsp_full = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        chk("rand_done", 128'(rsps), 128'(target));

        chk("protocol_viol", 128'(viol), 128'(0));
        chk("err_final", 128'(err_count), 128'(err_model));
        chk("exp_drained", 128'(exp_q.size()), 128'(0));
        chk("plan_drained", 128'(plan_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB-side consumer of the bridge's clock-crossing command FIFO, running in the FIFO's read clock domain. It pops one command word per transfer, runs a single APB transfer through SETUP and ACCESS, and pushes one response word per command into the response FIFO heading back to the AHB side. It also enforces a PREADY timeout so a hung slave cannot stall the bridge.

## Interface
Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; PSTRB width is DATA_W/8.
- TIMEOUT, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- rclk  in  1  single clock (APB PCLK domain).
- reset  in  1  synchronous, active-high reset.
- cmd_empty  in  1  command FIFO empty flag (registered).
- cmd_ren  out  1  command FIFO pop; one-cycle pulse.
- cmd_rdata  in  CMD_W  command word, valid the cycle after cmd_ren (registered read).
- rsp_full  in  1  response FIFO full flag.
- rsp_wen  out  1  response FIFO push; one-cycle pulse.
- rsp_wdata  out  RSP_W  response word.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB write strobes.
- pready, pslverr  in  1  APB slave response.
- prdata  in  DATA_W  APB read data.
- busy  out  1  high in every state except IDLE.
- err_count  out  16  saturating count of slverr and timeout responses.

## Operation
- Command word, MSB to LSB: {write, strb, addr, wdata}. CMD_W = 1 + DATA_W/8 + ADDR_W + DATA_W, which is 69 at defaults.
- Response word, MSB to LSB: {timeout, slverr, rdata}. RSP_W = DATA_W + 2. For write commands, rdata = 0.
- The FSM has five states: IDLE, FETCH, SETUP, ACCESS, RESP.
- IDLE: when !cmd_empty, assert cmd_ren for one cycle and go to FETCH. Otherwise stay in IDLE.
- FETCH: latch cmd_rdata into the command register, then go to SETUP.
- SETUP: psel=1, penable=0. paddr, pwrite, pwdata and pstrb come from the command register. Go to ACCESS.
- ACCESS: psel=1, penable=1.
  - If pready=1: capture prdata (reads only) and pslverr, then go to RESP.
  - If the timeout expires first: set timeout=1, slverr=0, rdata=0, then go to RESP.
- RESP: psel=0, penable=0. When !rsp_full, pulse rsp_wen with the latched response.
  - After the push, if !cmd_empty, pulse cmd_ren in the same cycle and go to FETCH; otherwise go to IDLE.
  - While rsp_full=1, hold in RESP indefinitely with no push.
- Timeout counter:
  - Cleared on entry to ACCESS; increments each ACCESS cycle with pready=0.
  - Abort happens in the cycle where the count equals TIMEOUT-1 and pready=0.
  - pready=1 in that same cycle wins, and the transfer completes normally.
- pwdata and pstrb are driven to 0 for reads. paddr, pwrite, pwdata and pstrb hold stable from SETUP through the final ACCESS cycle.
- err_count increments by 1 on each rsp_wen whose timeout or slverr bit is set, and saturates at 0xFFFF.
- There is exactly one response push per command pop. No commands are dropped or duplicated.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, cmd_ren=0, rsp_wen=0, rsp_wdata=0, busy=0, err_count=0. The FSM resets to IDLE and the timeout counter to 0.
- Zero-wait read, with cmd_ren at cycle 0:
  - FETCH at cycle 1.
  - SETUP at cycle 2.
  - ACCESS at cycle 3, with pready=1.
  - rsp_wen at cycle 4.
- Steady-state throughput: one command per 4 cycles (RESP overlaps the next cmd_ren).
- N wait states add N cycles to the ACCESS phase.
- The worst-case ACCESS phase is TIMEOUT cycles.
- Outputs are registered except cmd_ren and rsp_wen, which are decoded from state plus cmd_empty / rsp_full.
- Reset asserted mid-transfer: all outputs return to reset values at the next rclk edge. The in-flight command is discarded with no response. Any FIFO contents are the owner's concern.
- cmd_ren is never asserted while cmd_empty=1. rsp_wen is never asserted while rsp_full=1.

## Structure
- Package apb_bridge_pkg holds:
  - the state enum;
  - the command and response packed structs;
  - CMD_W and RSP_W as functions of ADDR_W and DATA_W.
- A sub-module apb_timeout_cnt holds the timeout counter, with inputs clr, en, pready and output expired.
- The rest is a single FSM module.

## Test plan
- Write 0xDEADBEEF to 0x1000 with strb=0xF and pready tied to 1:
  - APB SETUP/ACCESS sequence takes 2 cycles.
  - The response word is {0,0,0x0}.
  - rsp_wen fires 4 cycles after cmd_ren.
- Read from 0x2004 with 3 wait states and prdata=0x12345678:
  - penable is held high for 4 cycles.
  - The response is {0,0,0x12345678}.
- Read with pslverr=1:
  - The response is {0,1,prdata}.
  - err_count goes to 1.
- TIMEOUT=8 with pready held at 0:
  - Abort after 8 ACCESS cycles.
  - The response is {1,0,0}.
  - psel drops to 0 next cycle.
  - err_count increments.
- 4 back-to-back commands with rsp_full held at 1 for 10 cycles during the 2nd response:
  - The FSM holds in RESP and issues no extra cmd_ren.
  - All 4 responses arrive in order.
- Reset pulse during ACCESS:
  - psel and penable are 0 at the next edge.
  - No rsp_wen is issued.
  - The next command starts from IDLE cleanly.
